// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand, adder-slice and result signals of the nibble-serial add sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;

  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_ci;
  logic [3:0]   add_s;
  logic         add_co;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;

  modport master (
    output in_valid, in_a, in_b, in_ci, out_ready, add_s, add_co,
    input  in_ready, out_valid, out_sum, out_co, add_a, add_b, add_ci
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, out_ready, add_s, add_co,
    output in_ready, out_valid, out_sum, out_co, add_a, add_b, add_ci
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add through one external 4-bit slice; out_valid NIBBLES edges after accept.
// in_ready only in IDLE; the result is held stable in DONE until out_ready.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [CW-1:0]             cnt;
  logic [NIBBLES-1:0][3:0]   a_reg;
  logic [NIBBLES-1:0][3:0]   b_reg;
  logic [NIBBLES-1:0][3:0]   sum_reg;
  logic                      carry_reg;
  logic                      last_nib;

  assign last_nib    = (cnt == CNT_LAST);
  assign bus.out_sum = sum_reg;
  assign bus.out_co  = carry_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            carry_reg <= bus.in_ci;
            cnt       <= '0;
          end
        end
        RUN: begin
          // adder outputs are captured directly; the slice must settle in-cycle
          sum_reg[cnt] <= bus.add_s;
          carry_reg    <= bus.add_co;
          if (!last_nib) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = 4'h0;
    bus.add_b     = 4'h0;
    bus.add_ci    = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.add_a  = a_reg[cnt];
        bus.add_b  = b_reg[cnt];
        bus.add_ci = carry_reg;
        if (last_nib) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized and directed bench; reference is plain wide arithmetic plus a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // external ripple-carry slice
  assign {bus.add_co, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle_drive(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_add_a"},     32'(bus.add_a), 32'd0);
    chk({tag, "_add_b"},     32'(bus.add_b), 32'd0);
    chk({tag, "_add_ci"},    32'(bus.add_ci), 32'd0);
  endtask

  // Caller is at a negedge with the DUT in IDLE. busy=1 keeps presenting junk while not IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold, input bit busy,
                        input logic [W-1:0] ja, input logic [W-1:0] jb);
    logic [W:0]  exp_full;
    logic [63:0] mask;
    logic [63:0] part;
    exp_full = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
    chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_ci    = ci;
    bus.out_ready = 1'b0;
    step();
    if (busy) begin
      bus.in_a  = ja;
      bus.in_b  = jb;
      bus.in_ci = ~ci;
    end else begin
      bus.in_valid = 1'b0;
    end
    for (int k = 0; k < NIBBLES; k++) begin
      mask = (64'd1 << (4 * k)) - 64'd1;
      part = ((64'(a) & mask) + (64'(b) & mask) + 64'(ci)) >> (4 * k);
      chk("run_add_a",     32'(bus.add_a), 32'((a >> (4 * k)) & 4'hF));
      chk("run_add_b",     32'(bus.add_b), 32'((b >> (4 * k)) & 4'hF));
      chk("run_add_ci",    32'(bus.add_ci), 32'(part[0]));
      chk("run_in_ready",  32'(bus.in_ready), 32'd0);
      chk("run_out_valid", 32'(bus.out_valid), 32'd0);
      step();
    end
    chk("done_out_valid", 32'(bus.out_valid), 32'd1);
    chk("done_out_sum",   32'(bus.out_sum), 32'(exp_full[W-1:0]));
    chk("done_out_co",    32'(bus.out_co), 32'(exp_full[W]));
    chk("done_add_a",     32'(bus.add_a), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_sum",   32'(bus.out_sum), 32'(exp_full[W-1:0]));
      chk("hold_out_co",    32'(bus.out_co), 32'(exp_full[W]));
      chk("hold_in_ready",  32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_in_ready",  32'(bus.in_ready), 32'd1);
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_out_sum",   32'(bus.out_sum), 32'(exp_full[W-1:0]));
    chk("post_out_co",    32'(bus.out_co), 32'(exp_full[W]));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_ci     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk_idle_drive("reset");
    chk("reset_out_sum", 32'(bus.out_sum), 32'd0);
    chk("reset_out_co",  32'(bus.out_co), 32'd0);
    rst_n = 1'b1;
    step();
    chk_idle_drive("idle");

    run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0, '0, '0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, '0, '0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, '0, '0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 5, 1'b0, '0, '0);

    // busy input: junk offered during RUN/DONE, taken only once back in IDLE
    run_op(16'h0F0F, 16'h7001, 1'b0, 2, 1'b1, 16'hABCD, 16'h1111);
    run_op(16'hABCD, 16'h1111, 1'b1, 0, 1'b0, '0, '0);

    // reset at cnt==2 discards the operation
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h8888;
    bus.in_b     = 16'h8888;
    bus.in_ci    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("mid_add_a_cnt2", 32'(bus.add_a), 32'h8);
    rst_n = 1'b0;
    step();
    chk_idle_drive("midrst");
    chk("midrst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("midrst_out_co",  32'(bus.out_co), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NIBBLES + 2; i++) begin
      step();
      chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(16'h2468, 16'h1357, 1'b0, 0, 1'b0, '0, '0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 8 == 0) ra = '1;
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
